// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - register-file sizing shared by rename, ROB and free list
package rob_pkg;

    localparam int NUM_ARCH_REGS = 32;
    localparam int NUM_PHYS_REGS = 64;
    localparam int PREG_W        = $clog2(NUM_PHYS_REGS);

    typedef logic [PREG_W-1:0] preg_t;

endpackage

// File: rtl/popcount2.sv
// rtl/popcount2.sv - population count of a 2-bit vector
module popcount2 (
    input  logic [1:0] bits,
    output logic [1:0] count
);

    assign count = {bits[1] & bits[0], bits[1] ^ bits[0]};

endmodule

// File: rtl/free_list.sv
// rtl/free_list.sv - 2-wide physical-register free list with speculative and architectural heads
module free_list #(
    parameter int NUM_ARCH_REGS = rob_pkg::NUM_ARCH_REGS,
    parameter int NUM_PHYS_REGS = rob_pkg::NUM_PHYS_REGS,
    parameter int PREG_W        = $clog2(NUM_PHYS_REGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             alloc_req,
    output logic                   alloc_grant,
    output logic [1:0][PREG_W-1:0] alloc_preg,
    input  logic [1:0]             commit_alloc,
    input  logic [1:0]             free_valid,
    input  logic [1:0][PREG_W-1:0] free_preg,
    input  logic                   flush,
    output logic [PREG_W:0]        free_count,
    output logic                   overflow_err
);

    localparam int CW = PREG_W + 1;
    localparam logic [PREG_W:0] DEPTH = CW'(NUM_PHYS_REGS);

    logic [PREG_W-1:0] fl [NUM_PHYS_REGS];
    logic [PREG_W-1:0] spec_head, arch_head, tail;
    logic [PREG_W:0]   spec_cnt, arch_cnt;

    logic [1:0]        n_alloc, n_commit, n_push, granted;
    logic [PREG_W:0]   room;
    logic              wr0, wr1, push_drop;
    logic [PREG_W-1:0] tail1;
    logic [PREG_W-1:0] arch_head_next, spec_head_next, tail_next;
    logic [PREG_W:0]   arch_cnt_next, spec_cnt_next;

    popcount2 u_pc_alloc  (.bits(alloc_req),    .count(n_alloc));
    popcount2 u_pc_commit (.bits(commit_alloc), .count(n_commit));
    popcount2 u_pc_push   (.bits({wr1, wr0}),   .count(n_push));

    // All-or-nothing grant; slot 1 skips past slot 0 only when slot 0 is asking
    assign alloc_grant   = (spec_cnt >= CW'(n_alloc)) && !flush;
    assign alloc_preg[0] = fl[spec_head];
    assign alloc_preg[1] = fl[spec_head + PREG_W'(alloc_req[0])];
    assign free_count    = spec_cnt;

    // Space is judged against the architectural head: entries between it and
    // spec_head still hold pregs that a flush will hand back out.
    assign room      = DEPTH - arch_cnt;
    assign wr0       = free_valid[0] && (room != '0);
    assign wr1       = free_valid[1] && (room > CW'(wr0));
    assign push_drop = (free_valid[0] && !wr0) || (free_valid[1] && !wr1);
    assign tail1     = tail + PREG_W'(wr0);

    always_comb begin
        granted        = alloc_grant ? n_alloc : 2'd0;
        arch_head_next = arch_head + PREG_W'(n_commit);
        arch_cnt_next  = arch_cnt - CW'(n_commit) + CW'(n_push);
        tail_next      = tail + PREG_W'(n_push);
        spec_head_next = spec_head + PREG_W'(granted);
        spec_cnt_next  = spec_cnt - CW'(granted) + CW'(n_push);
        if (flush) begin
            spec_head_next = arch_head_next;
            spec_cnt_next  = arch_cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PHYS_REGS; i++) begin
                fl[i] <= (i < NUM_PHYS_REGS - NUM_ARCH_REGS) ? PREG_W'(NUM_ARCH_REGS + i) : '0;
            end
            spec_head    <= '0;
            arch_head    <= '0;
            tail         <= PREG_W'(NUM_PHYS_REGS - NUM_ARCH_REGS);
            spec_cnt     <= CW'(NUM_PHYS_REGS - NUM_ARCH_REGS);
            arch_cnt     <= CW'(NUM_PHYS_REGS - NUM_ARCH_REGS);
            overflow_err <= 1'b0;
        end else begin
            if (wr0) fl[tail]  <= free_preg[0];
            if (wr1) fl[tail1] <= free_preg[1];
            spec_head <= spec_head_next;
            arch_head <= arch_head_next;
            tail      <= tail_next;
            spec_cnt  <= spec_cnt_next;
            arch_cnt  <= arch_cnt_next;
            if (push_drop) overflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_free_list.sv
// tb/tb_free_list.sv - directed self-checking bench for free_list
module tb_free_list;
    import rob_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [1:0]             alloc_req;
    logic                   alloc_grant;
    logic [1:0][PREG_W-1:0] alloc_preg;
    logic [1:0]             commit_alloc;
    logic [1:0]             free_valid;
    logic [1:0][PREG_W-1:0] free_preg;
    logic                   flush;
    logic [PREG_W:0]        free_count;
    logic                   overflow_err;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    free_list dut (
        .clk(clk), .rst(rst),
        .alloc_req(alloc_req), .alloc_grant(alloc_grant), .alloc_preg(alloc_preg),
        .commit_alloc(commit_alloc), .free_valid(free_valid), .free_preg(free_preg),
        .flush(flush), .free_count(free_count), .overflow_err(overflow_err)
    );

    // The ROB contract: the architectural head never overtakes the speculative head
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            assert (dut.arch_cnt >= dut.spec_cnt)
                else $error("arch_head passed spec_head: arch_cnt=%0d spec_cnt=%0d", dut.arch_cnt, dut.spec_cnt);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_req = 2'b00; commit_alloc = 2'b00; free_valid = 2'b00;
        free_preg = '0; flush = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (free_count !== 7'd32) begin tests_failed++; $display("FAIL reset_free_count: got %0d expected 32", free_count); end
        tests_run++;
        if (overflow_err !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %0b expected 0", overflow_err); end
        alloc_req = 2'b00; #1;
        tests_run++;
        if (alloc_grant !== 1'b1) begin tests_failed++; $display("FAIL grant_n0: got %0b expected 1", alloc_grant); end
        alloc_req = 2'b11; #1;
        tests_run++;
        if (alloc_grant !== 1'b1 || alloc_preg[0] !== 6'd32 || alloc_preg[1] !== 6'd33) begin
            tests_failed++;
            $display("FAIL reset_alloc2: got grant=%0b {%0d,%0d} expected grant=1 {33,32}", alloc_grant, alloc_preg[1], alloc_preg[0]);
        end
        step();
        tests_run++;
        if (free_count !== 7'd30 || alloc_preg[0] !== 6'd34 || alloc_preg[1] !== 6'd35) begin
            tests_failed++;
            $display("FAIL after_alloc2: got cnt=%0d {%0d,%0d} expected cnt=30 {35,34}", free_count, alloc_preg[1], alloc_preg[0]);
        end
        alloc_req = 2'b00;
    endtask

    task automatic test_slot_order();
        do_reset();
        alloc_req = 2'b10; #1;
        tests_run++;
        if (alloc_grant !== 1'b1 || alloc_preg[1] !== 6'd32) begin
            tests_failed++;
            $display("FAIL slot1_only: got grant=%0b preg1=%0d expected grant=1 preg1=32", alloc_grant, alloc_preg[1]);
        end
        step();
        alloc_req = 2'b01; #1;
        tests_run++;
        if (alloc_grant !== 1'b1 || alloc_preg[0] !== 6'd33) begin
            tests_failed++;
            $display("FAIL slot0_next: got grant=%0b preg0=%0d expected grant=1 preg0=33", alloc_grant, alloc_preg[0]);
        end
        step();
        alloc_req = 2'b00;
        tests_run++;
        if (free_count !== 7'd30) begin tests_failed++; $display("FAIL slot_order_cnt: got %0d expected 30", free_count); end
    endtask

    task automatic test_exhaust();
        do_reset();
        alloc_req = 2'b11;
        repeat (15) step();
        alloc_req = 2'b01;
        step();
        alloc_req = 2'b11; #1;
        tests_run++;
        if (alloc_grant !== 1'b0) begin tests_failed++; $display("FAIL short_grant: got %0b expected 0", alloc_grant); end
        step();
        tests_run++;
        if (free_count !== 7'd1) begin tests_failed++; $display("FAIL short_cnt: got %0d expected 1", free_count); end
        alloc_req = 2'b01; #1;
        tests_run++;
        if (alloc_grant !== 1'b1 || alloc_preg[0] !== 6'd63) begin
            tests_failed++;
            $display("FAIL last_preg: got grant=%0b preg0=%0d expected grant=1 preg0=63", alloc_grant, alloc_preg[0]);
        end
        step();
        alloc_req = 2'b00; #1;
        tests_run++;
        if (free_count !== 7'd0) begin tests_failed++; $display("FAIL empty_cnt: got %0d expected 0", free_count); end
        tests_run++;
        if (alloc_grant !== 1'b1) begin tests_failed++; $display("FAIL empty_n0_grant: got %0b expected 1", alloc_grant); end
    endtask

    task automatic test_free_bypass();
        alloc_req = 2'b01; free_valid = 2'b01; free_preg[0] = 6'd5; #1;
        tests_run++;
        if (alloc_grant !== 1'b0) begin tests_failed++; $display("FAIL bypass_same_cycle: got grant=%0b expected 0", alloc_grant); end
        step();
        idle();
        alloc_req = 2'b01; #1;
        tests_run++;
        if (alloc_grant !== 1'b1 || alloc_preg[0] !== 6'd5 || free_count !== 7'd1) begin
            tests_failed++;
            $display("FAIL bypass_next_cycle: got grant=%0b preg0=%0d cnt=%0d expected grant=1 preg0=5 cnt=1", alloc_grant, alloc_preg[0], free_count);
        end
        alloc_req = 2'b00;
    endtask

    task automatic test_flush_restore();
        do_reset();
        alloc_req = 2'b11;
        repeat (3) step();
        alloc_req = 2'b00; commit_alloc = 2'b11;
        step();
        commit_alloc = 2'b00; flush = 1'b1; alloc_req = 2'b01; #1;
        tests_run++;
        if (alloc_grant !== 1'b0) begin tests_failed++; $display("FAIL flush_grant: got %0b expected 0", alloc_grant); end
        step();
        flush = 1'b0; #1;
        tests_run++;
        if (free_count !== 7'd30 || alloc_grant !== 1'b1 || alloc_preg[0] !== 6'd34) begin
            tests_failed++;
            $display("FAIL flush_restore: got cnt=%0d grant=%0b preg0=%0d expected cnt=30 grant=1 preg0=34", free_count, alloc_grant, alloc_preg[0]);
        end
        alloc_req = 2'b00;
    endtask

    task automatic test_flush_free();
        logic [PREG_W-1:0] exp_preg;
        do_reset();
        alloc_req = 2'b11;
        repeat (2) step();
        alloc_req = 2'b00; commit_alloc = 2'b11;
        step();
        // arch_cnt is 30 here; commit one and free two during the flush
        flush = 1'b1; commit_alloc = 2'b01; free_valid = 2'b11;
        free_preg[0] = 6'd7; free_preg[1] = 6'd5;
        step();
        idle(); #1;
        tests_run++;
        if (free_count !== 7'd31) begin tests_failed++; $display("FAIL flush_free_cnt: got %0d expected 31", free_count); end
        for (int k = 0; k < 31; k++) begin
            exp_preg = (k < 29) ? PREG_W'(35 + k) : ((k == 29) ? 6'd7 : 6'd5);
            alloc_req = 2'b01; #1;
            tests_run++;
            if (alloc_grant !== 1'b1 || alloc_preg[0] !== exp_preg) begin
                tests_failed++;
                $display("FAIL flush_free_order[%0d]: got grant=%0b preg0=%0d expected grant=1 preg0=%0d", k, alloc_grant, alloc_preg[0], exp_preg);
            end
            step();
        end
        alloc_req = 2'b00;
        tests_run++;
        if (free_count !== 7'd0) begin tests_failed++; $display("FAIL flush_free_drain: got %0d expected 0", free_count); end
    endtask

    task automatic test_wrap_overflow();
        preg_t q[$];
        preg_t exp_preg;
        do_reset();
        for (int i = 32; i < 64; i++) q.push_back(PREG_W'(i));
        for (int k = 0; k < 40; k++) begin
            exp_preg = q.pop_front();
            q.push_back(exp_preg);
            alloc_req = 2'b01; commit_alloc = 2'b01; free_valid = 2'b01; free_preg[0] = exp_preg; #1;
            tests_run++;
            if (alloc_grant !== 1'b1 || alloc_preg[0] !== exp_preg) begin
                tests_failed++;
                $display("FAIL wrap_order[%0d]: got grant=%0b preg0=%0d expected grant=1 preg0=%0d", k, alloc_grant, alloc_preg[0], exp_preg);
            end
            step();
        end
        idle(); #1;
        tests_run++;
        if (free_count !== 7'd32 || overflow_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_end: got cnt=%0d ovf=%0b expected cnt=32 ovf=0", free_count, overflow_err);
        end
        for (int k = 0; k < 16; k++) begin
            free_valid = 2'b11; free_preg[0] = PREG_W'(2 * k); free_preg[1] = PREG_W'(2 * k + 1);
            step();
        end
        idle(); #1;
        tests_run++;
        if (free_count !== 7'd64 || overflow_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_list: got cnt=%0d ovf=%0b expected cnt=64 ovf=0", free_count, overflow_err);
        end
        free_valid = 2'b01; free_preg[0] = 6'd9;
        step();
        idle();
        repeat (3) step();
        tests_run++;
        if (free_count !== 7'd64 || overflow_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL overflow_sticky: got cnt=%0d ovf=%0b expected cnt=64 ovf=1", free_count, overflow_err);
        end
        do_reset();
        tests_run++;
        if (overflow_err !== 1'b0 || free_count !== 7'd32) begin
            tests_failed++;
            $display("FAIL overflow_cleared: got cnt=%0d ovf=%0b expected cnt=32 ovf=0", free_count, overflow_err);
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        test_reset();
        test_slot_order();
        test_exhaust();
        test_free_bypass();
        test_flush_restore();
        test_flush_free();
        test_wrap_overflow();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
